// File: rtl/e203_exu_div_arb.sv
// Purpose: round-robin arbiter/sequencer sharing one divider between two requesters.
// Latency: accept in T -> div_i_valid in T+1; result path is combinational (0 cycles).
// Backpressure: one op in flight; requesters stall in ISSUE/BUSY; div_o_ready follows the owner's rsp ready.
//
// Ports: req0_*/req1_* valid-ready op inputs (rs1, rs2, info, itag);
//        rsp0_*/rsp1_* valid-ready result outputs (wdat, err, itag);
//        div_i_* op to the divider, div_o_* result from the divider;
//        flush_pulse in (requester 0 only), div_flush_pulse out.
`timescale 1ns/1ps
module e203_exu_div_arb #(
    parameter int XLEN   = 32,
    parameter int ITAG_W = 2,
    parameter int INFO_W = 13
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [XLEN-1:0]   req0_rs1,
    input  logic [XLEN-1:0]   req0_rs2,
    input  logic [INFO_W-1:0] req0_info,
    input  logic [ITAG_W-1:0] req0_itag,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [XLEN-1:0]   req1_rs1,
    input  logic [XLEN-1:0]   req1_rs2,
    input  logic [INFO_W-1:0] req1_info,
    input  logic [ITAG_W-1:0] req1_itag,

    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [XLEN-1:0]   rsp0_wdat,
    output logic              rsp0_err,
    output logic [ITAG_W-1:0] rsp0_itag,

    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [XLEN-1:0]   rsp1_wdat,
    output logic              rsp1_err,
    output logic [ITAG_W-1:0] rsp1_itag,

    input  logic              flush_pulse,

    output logic              div_i_valid,
    input  logic              div_i_ready,
    output logic [XLEN-1:0]   div_i_rs1,
    output logic [XLEN-1:0]   div_i_rs2,
    output logic [INFO_W-1:0] div_i_info,
    output logic [ITAG_W-1:0] div_i_itag,

    input  logic              div_o_valid,
    output logic              div_o_ready,
    input  logic [XLEN-1:0]   div_o_wdat,
    input  logic              div_o_err,

    output logic              div_flush_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_BUSY  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;
    logic                rr_last_q, rr_last_d;
    logic [XLEN-1:0]     rs1_q, rs1_d;
    logic [XLEN-1:0]     rs2_q, rs2_d;
    logic [INFO_W-1:0]   info_q, info_d;
    logic [ITAG_W-1:0]   itag_q, itag_d;

    logic st_idle, st_issue, st_busy;
    logic win0, win1;
    logic acc0, acc1;
    logic flush0;
    logic res_hs;

    assign st_idle  = (state_q == ST_IDLE);
    assign st_issue = (state_q == ST_ISSUE);
    assign st_busy  = (state_q == ST_BUSY);

    // On a tie the requester that did not win last time takes the grant.
    assign win0 = req0_valid & (~req1_valid | rr_last_q);
    assign win1 = req1_valid & (~req0_valid | ~rr_last_q);

    // Requester 0 is held off during a flush so a squashed op is never captured.
    assign req0_ready = st_idle & win0 & ~flush_pulse;
    assign req1_ready = st_idle & win1;
    assign acc0       = req0_valid & req0_ready;
    assign acc1       = req1_valid & req1_ready;

    // Only requester-0 ops are subject to flush.
    assign flush0 = flush_pulse & ~owner_q;

    assign div_i_valid = st_issue;
    assign div_i_rs1   = rs1_q;
    assign div_i_rs2   = rs2_q;
    assign div_i_info  = info_q;
    assign div_i_itag  = itag_q;

    assign div_o_ready = st_busy & (owner_q ? rsp1_ready : rsp0_ready);
    assign res_hs      = div_o_valid & div_o_ready;

    assign rsp0_valid = st_busy & div_o_valid & ~owner_q;
    assign rsp1_valid = st_busy & div_o_valid &  owner_q;
    assign rsp0_wdat  = div_o_wdat;
    assign rsp1_wdat  = div_o_wdat;
    assign rsp0_err   = div_o_err;
    assign rsp1_err   = div_o_err;
    assign rsp0_itag  = itag_q;
    assign rsp1_itag  = itag_q;

    // A result handshake in the same cycle wins over the flush.
    assign div_flush_pulse = st_busy & flush0 & ~res_hs;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_last_d = rr_last_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        info_d    = info_q;
        itag_d    = itag_q;
        unique case (state_q)
            ST_IDLE: begin
                if (acc0) begin
                    rs1_d     = req0_rs1;
                    rs2_d     = req0_rs2;
                    info_d    = req0_info;
                    itag_d    = req0_itag;
                    owner_d   = 1'b0;
                    rr_last_d = 1'b0;
                    state_d   = ST_ISSUE;
                end else if (acc1) begin
                    rs1_d     = req1_rs1;
                    rs2_d     = req1_rs2;
                    info_d    = req1_info;
                    itag_d    = req1_itag;
                    owner_d   = 1'b1;
                    rr_last_d = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // If the divider takes the op in the flush cycle it owns it now;
                // follow it into BUSY so its result is not orphaned.
                if (div_i_ready) begin
                    state_d = ST_BUSY;
                end else if (flush0) begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (res_hs || flush0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= 1'b0;
            rr_last_q <= 1'b1;
            rs1_q     <= '0;
            rs2_q     <= '0;
            info_q    <= '0;
            itag_q    <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_last_q <= rr_last_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            info_q    <= info_d;
            itag_q    <= itag_d;
        end
    end

endmodule

// File: tb/tb_e203_exu_div_arb.sv
`timescale 1ns/1ps
module tb_e203_exu_div_arb;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_rs1, req0_rs2;
    logic [12:0] req0_info;
    logic [1:0]  req0_itag;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_rs1, req1_rs2;
    logic [12:0] req1_info;
    logic [1:0]  req1_itag;
    logic        rsp0_valid, rsp0_ready, rsp0_err;
    logic [31:0] rsp0_wdat;
    logic [1:0]  rsp0_itag;
    logic        rsp1_valid, rsp1_ready, rsp1_err;
    logic [31:0] rsp1_wdat;
    logic [1:0]  rsp1_itag;
    logic        flush_pulse;
    logic        div_i_valid, div_i_ready;
    logic [31:0] div_i_rs1, div_i_rs2;
    logic [12:0] div_i_info;
    logic [1:0]  div_i_itag;
    logic        div_o_valid, div_o_ready, div_o_err;
    logic [31:0] div_o_wdat;
    logic        div_flush_pulse;

    int n_chk  = 0;
    int n_fail = 0;

    e203_exu_div_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_rs1(req0_rs1),
        .req0_rs2(req0_rs2), .req0_info(req0_info), .req0_itag(req0_itag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_rs1(req1_rs1),
        .req1_rs2(req1_rs2), .req1_info(req1_info), .req1_itag(req1_itag),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_wdat(rsp0_wdat),
        .rsp0_err(rsp0_err), .rsp0_itag(rsp0_itag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_wdat(rsp1_wdat),
        .rsp1_err(rsp1_err), .rsp1_itag(rsp1_itag),
        .flush_pulse(flush_pulse),
        .div_i_valid(div_i_valid), .div_i_ready(div_i_ready), .div_i_rs1(div_i_rs1),
        .div_i_rs2(div_i_rs2), .div_i_info(div_i_info), .div_i_itag(div_i_itag),
        .div_o_valid(div_o_valid), .div_o_ready(div_o_ready), .div_o_wdat(div_o_wdat),
        .div_o_err(div_o_err), .div_flush_pulse(div_flush_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  t;
        logic [12:0] inf;
        logic [31:0] q;
        logic        e;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic set_req(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] t, input logic [12:0] inf);
        if (!r) begin
            req0_valid = v; req0_rs1 = a; req0_rs2 = b; req0_itag = t; req0_info = inf;
        end else begin
            req1_valid = v; req1_rs1 = a; req1_rs2 = b; req1_itag = t; req1_info = inf;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 0; req0_rs1 = 0; req0_rs2 = 0; req0_info = 0; req0_itag = 0;
        req1_valid = 0; req1_rs1 = 0; req1_rs2 = 0; req1_info = 0; req1_itag = 0;
        rsp0_ready = 0; rsp1_ready = 0; flush_pulse = 0;
        div_i_ready = 0; div_o_valid = 0; div_o_wdat = 0; div_o_err = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called at a negedge in IDLE with only requester r valid; ends at the negedge in ISSUE.
    task automatic start_op(input logic r, input logic [31:0] a, input logic [31:0] b,
                            input logic [1:0] t, input logic [12:0] inf, input string nm);
        set_req(r, 1'b1, a, b, t, inf);
        #1;
        chk({nm, "_ready_win"},  r ? req1_ready : req0_ready, 1'b1);
        chk({nm, "_ready_lose"}, r ? req0_ready : req1_ready, 1'b0);
        @(posedge clk);
        @(negedge clk);
        set_req(r, 1'b0, '0, '0, '0, '0);
    endtask

    // Called at a negedge in ISSUE; divider accepts at once.
    task automatic issue_hs();
        div_i_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        div_i_ready = 1'b0;
    endtask

    // Called at a negedge in ISSUE; runs the op to completion, ends at a negedge in IDLE.
    task automatic finish_op(input logic r, input logic [31:0] a, input logic [31:0] b,
                             input logic [1:0] t, input logic [12:0] inf,
                             input logic [31:0] q, input logic e, input string nm);
        #1;
        chk({nm, "_div_i_valid"}, div_i_valid, 1'b1);
        chk({nm, "_div_i_rs1"},   div_i_rs1, a);
        chk({nm, "_div_i_rs2"},   div_i_rs2, b);
        chk({nm, "_div_i_info"},  div_i_info, inf);
        chk({nm, "_div_i_itag"},  div_i_itag, t);
        issue_hs();
        div_o_valid = 1'b1; div_o_wdat = q; div_o_err = e;
        if (r) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
        #1;
        chk({nm, "_rsp_valid"},   r ? rsp1_valid : rsp0_valid, 1'b1);
        chk({nm, "_rsp_other"},   r ? rsp0_valid : rsp1_valid, 1'b0);
        chk({nm, "_rsp_wdat"},    r ? rsp1_wdat : rsp0_wdat, q);
        chk({nm, "_rsp_err"},     r ? rsp1_err : rsp0_err, e);
        chk({nm, "_rsp_itag"},    r ? rsp1_itag : rsp0_itag, t);
        chk({nm, "_div_o_ready"}, div_o_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        // div_o_valid still high: a non-IDLE state would show it as rsp valid.
        chk({nm, "_idle_rsp0"},    rsp0_valid, 1'b0);
        chk({nm, "_idle_rsp1"},    rsp1_valid, 1'b0);
        chk({nm, "_idle_div_i_v"}, div_i_valid, 1'b0);
        div_o_valid = 1'b0; div_o_err = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'h64,        32'h7, 2'd1, 13'h0a5,  32'hE,         1'b0};
        vecs[1] = '{1'b1, 32'h3E8,       32'hA, 2'd2, 13'h1234, 32'h64,        1'b0};
        vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h1, 2'd3, 13'h0001, 32'hFFFF_FFFF, 1'b0};
        vecs[3] = '{1'b1, 32'h10,        32'h0, 2'd0, 13'h1FFF, 32'hFFFF_FFFF, 1'b1};

        // Reset state
        do_reset();
        #1;
        chk("rst_div_i_valid", div_i_valid, 1'b0);
        chk("rst_div_o_ready", div_o_ready, 1'b0);
        chk("rst_rsp0_valid",  rsp0_valid, 1'b0);
        chk("rst_rsp1_valid",  rsp1_valid, 1'b0);
        chk("rst_div_flush",   div_flush_pulse, 1'b0);
        chk("rst_div_i_rs1",   div_i_rs1, 32'h0);
        chk("rst_div_i_itag",  div_i_itag, 2'd0);
        chk("rst_req1_ready",  req1_ready, 1'b0);
        @(negedge clk);

        // Single op from requester 0: 0x64 / 0x7 = 0xE
        start_op(1'b0, 32'h64, 32'h7, 2'd2, 13'h0055, "single");
        finish_op(1'b0, 32'h64, 32'h7, 2'd2, 13'h0055, 32'hE, 1'b0, "single");

        // Tie from reset: req0 first, then req1, next tie req0 again
        do_reset();
        set_req(1'b0, 1'b1, 32'h64, 32'h7, 2'd1, 13'h0011);
        set_req(1'b1, 1'b1, 32'h20, 32'h4, 2'd2, 13'h0022);
        #1;
        chk("tie1_req0_ready", req0_ready, 1'b1);
        chk("tie1_req1_ready", req1_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        #1;
        chk("tie1_req1_wait_issue", req1_ready, 1'b0);
        finish_op(1'b0, 32'h64, 32'h7, 2'd1, 13'h0011, 32'hE, 1'b0, "tie1_op0");
        chk("tie1_req1_after", req1_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        set_req(1'b1, 1'b0, '0, '0, '0, '0);
        finish_op(1'b1, 32'h20, 32'h4, 2'd2, 13'h0022, 32'h8, 1'b0, "tie1_op1");
        @(negedge clk);
        set_req(1'b0, 1'b1, 32'h9, 32'h3, 2'd3, 13'h0033);
        set_req(1'b1, 1'b1, 32'hC, 32'h4, 2'd0, 13'h0044);
        #1;
        chk("tie2_req0_ready", req0_ready, 1'b1);
        chk("tie2_req1_ready", req1_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        finish_op(1'b0, 32'h9, 32'h3, 2'd3, 13'h0033, 32'h3, 1'b0, "tie2_op0");
        chk("tie2_req1_after", req1_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        set_req(1'b1, 1'b0, '0, '0, '0, '0);
        finish_op(1'b1, 32'hC, 32'h4, 2'd0, 13'h0044, 32'h3, 1'b0, "tie2_op1");

        // Divider stalls div_i_ready for 5 cycles; req1 waits
        set_req(1'b0, 1'b1, 32'hABCD_0000, 32'h100, 2'd1, 13'h0A0A);
        set_req(1'b1, 1'b1, 32'h77, 32'h7, 2'd3, 13'h0B0B);
        #1;
        chk("stall_req0_ready", req0_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        set_req(1'b0, 1'b0, '0, '0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("stall_div_i_valid", div_i_valid, 1'b1);
            chk("stall_div_i_rs1",   div_i_rs1, 32'hABCD_0000);
            chk("stall_div_i_rs2",   div_i_rs2, 32'h100);
            chk("stall_req1_ready",  req1_ready, 1'b0);
            @(negedge clk);
        end
        finish_op(1'b0, 32'hABCD_0000, 32'h100, 2'd1, 13'h0A0A, 32'hABCD00, 1'b0, "stall_op0");
        chk("stall_req1_after", req1_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        set_req(1'b1, 1'b0, '0, '0, '0, '0);
        finish_op(1'b1, 32'h77, 32'h7, 2'd3, 13'h0B0B, 32'h11, 1'b0, "stall_op1");

        // Flush while req0 op sits in ISSUE: dropped, no divider flush
        start_op(1'b0, 32'h50, 32'h5, 2'd1, 13'h0001, "fiss");
        flush_pulse = 1'b1;
        #1;
        chk("fiss_div_i_valid", div_i_valid, 1'b1);
        chk("fiss_div_flush",   div_flush_pulse, 1'b0);
        chk("fiss_req0_ready",  req0_ready, 1'b0);
        @(posedge clk); @(negedge clk);
        flush_pulse = 1'b0;
        #1;
        chk("fiss_dropped", div_i_valid, 1'b0);
        @(negedge clk);

        // Flush while req0 op in BUSY
        start_op(1'b0, 32'h60, 32'h6, 2'd2, 13'h0002, "fbusy");
        issue_hs();
        flush_pulse = 1'b1;
        #1;
        chk("fbusy_div_flush", div_flush_pulse, 1'b1);
        chk("fbusy_rsp0_valid", rsp0_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        flush_pulse = 1'b0;
        div_o_valid = 1'b1; rsp0_ready = 1'b1;
        #1;
        chk("fbusy_idle_rsp0",  rsp0_valid, 1'b0);
        chk("fbusy_idle_o_rdy", div_o_ready, 1'b0);
        chk("fbusy_idle_flush", div_flush_pulse, 1'b0);
        div_o_valid = 1'b0; rsp0_ready = 1'b0;
        @(negedge clk);

        // Flush while req1 op in BUSY: ignored
        start_op(1'b1, 32'h90, 32'h9, 2'd3, 13'h0003, "f1");
        issue_hs();
        flush_pulse = 1'b1;
        #1;
        chk("f1_div_flush", div_flush_pulse, 1'b0);
        @(posedge clk); @(negedge clk);
        flush_pulse = 1'b0;
        div_o_valid = 1'b1; div_o_wdat = 32'h10; rsp1_ready = 1'b1;
        #1;
        chk("f1_rsp1_valid", rsp1_valid, 1'b1);
        chk("f1_rsp1_wdat",  rsp1_wdat, 32'h10);
        chk("f1_rsp1_itag",  rsp1_itag, 2'd3);
        chk("f1_div_o_ready", div_o_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        chk("f1_idle_rsp1", rsp1_valid, 1'b0);
        div_o_valid = 1'b0;
        @(negedge clk);

        // rsp1_ready low for 3 cycles with a pending result
        start_op(1'b1, 32'hC8, 32'h2, 2'd1, 13'h0004, "bp");
        issue_hs();
        div_o_valid = 1'b1; div_o_wdat = 32'h64; div_o_err = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rsp1_valid",   rsp1_valid, 1'b1);
            chk("bp_div_o_ready",  div_o_ready, 1'b0);
            chk("bp_rsp1_wdat",    rsp1_wdat, 32'h64);
            chk("bp_rsp0_valid",   rsp0_valid, 1'b0);
            @(negedge clk);
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_div_o_ready_hi", div_o_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        rsp1_ready = 1'b0;
        #1;
        chk("bp_idle_rsp1", rsp1_valid, 1'b0);
        div_o_valid = 1'b0;
        @(negedge clk);

        // Table of single-requester ops
        for (int i = 0; i < 4; i++) begin
            start_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].inf, $sformatf("vec%0d", i));
            finish_op(vecs[i].r, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].inf,
                      vecs[i].q, vecs[i].e, $sformatf("vec%0d", i));
            @(negedge clk);
        end

        // Reset asserted mid-op returns to IDLE immediately
        start_op(1'b0, 32'h33, 32'h3, 2'd2, 13'h0005, "mrst");
        #1;
        chk("mrst_in_issue", div_i_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mrst_div_i_valid", div_i_valid, 1'b0);
        chk("mrst_div_i_rs1",   div_i_rs1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
